// File: rtl/mux_f_tree.sv
// mux_f_tree: F7/F8/F9-style mux tree with one enable per node, a selectable
// output register per output, and a length-checked serial configuration chain.
// Sits between the LUT array and the slice output/routing mux.
module mux_f_tree #(
    parameter int unsigned MUX_LEVEL = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [(1 << MUX_LEVEL)-1:0]   luts_out,
    input  logic [MUX_LEVEL-1:0]          addr,
    input  logic                          ce,
    output logic [(1 << MUX_LEVEL)-1:0]   out,
    input  logic                          cfg_shift,
    input  logic                          cfg_in,
    output logic                          cfg_out,
    input  logic                          cfg_commit,
    output logic                          cfg_err
);

    localparam int unsigned NUM_LUTS = 2 ** MUX_LEVEL;
    localparam int unsigned CFG_BITS = 2 * NUM_LUTS - 1;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 2);
    localparam int unsigned LUT_IW   = MUX_LEVEL;
    localparam int unsigned CFG_IW   = $clog2(CFG_BITS);
    localparam int unsigned LVL_IW   = (MUX_LEVEL > 1) ? $clog2(MUX_LEVEL) : 1;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2,
        S_OVER    = 2'd3
    } cnt_state_t;

    cnt_state_t             r_state;
    cnt_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CFG_BITS-1:0]    r_shadow;
    logic [CFG_BITS-1:0]    w_shadow_nxt;
    logic [CFG_BITS-1:0]    r_active;
    logic [CFG_BITS-1:0]    w_active_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic [NUM_LUTS-1:0]    r_oreg;
    logic [NUM_LUTS-1:0]    w_pre;
    logic [NUM_LUTS-1:0]    w_reg_en;

    // Tree evaluated in place: a level-L node at position j overwrites slot j,
    // leaving every slot i holding v(tz(i), i) and slot 0 holding the root.
    always_comb begin
        w_pre = luts_out;
        for (int l = 1; l <= int'(MUX_LEVEL); l++) begin
            for (int j = 0; j < int'(NUM_LUTS); j += (1 << l)) begin
                if (r_active[CFG_IW'(int'(NUM_LUTS) - (1 << (int'(MUX_LEVEL) - l + 1)) + (j >> l))]
                    && addr[LVL_IW'(l - 1)]) begin
                    w_pre[LUT_IW'(j)] = w_pre[LUT_IW'(j + (1 << (l - 1)))];
                end
            end
        end
    end

    // Per-output choice between the live tree value and its register.
    assign w_reg_en = r_active[CFG_BITS-1 -: NUM_LUTS];
    assign out      = (w_reg_en & r_oreg) | (~w_reg_en & w_pre);
    assign cfg_out  = r_shadow[0];
    assign cfg_err  = r_err;

    // Output registers track the tree whenever ce is high, enabled or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oreg <= '0;
        end else if (ce) begin
            r_oreg <= w_pre;
        end
    end

    // Config chain next state: commit has priority over shift and checks the
    // pre-edge count; the counter saturates one past a full load.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active;
        w_err_nxt    = r_err;
        if (cfg_commit) begin
            w_cnt_nxt = '0;
            if (r_state == S_FULL) begin
                w_active_nxt = r_shadow;
                w_err_nxt    = 1'b0;
            end else begin
                w_err_nxt    = 1'b1;
            end
        end else if (cfg_shift) begin
            w_shadow_nxt = {cfg_in, r_shadow[CFG_BITS-1:1]};
            if (r_state != S_OVER) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
        if (w_cnt_nxt == '0) begin
            w_state_nxt = S_EMPTY;
        end else if (w_cnt_nxt == CNT_W'(CFG_BITS)) begin
            w_state_nxt = S_FULL;
        end else if (w_cnt_nxt == CNT_W'(CFG_BITS + 1)) begin
            w_state_nxt = S_OVER;
        end else begin
            w_state_nxt = S_PARTIAL;
        end
    end

    // Config chain state register; reset discards any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
            r_err    <= w_err_nxt;
        end
    end

endmodule
